dump_sequencer: RTL and testbench

Sequences a channel dump from the capture RAMs to the UART transmitter once a capture has completed. It owns the RAM read port while dumping. It reads DEPTH samples of the selected channel in circular order, oldest first, starting at a latched start address. It hands each byte to the transmitter with a start/done handshake and pulses dump_fin when the trace is fully sent.

---
 rtl/dump_sequencer_if.sv | 36 +++
 rtl/dump_sequencer.sv | 99 +++++++++
 tb/tb_dump_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dump_sequencer_if.sv
// Bundle of request, RAM read and transmitter signals around the dump sequencer.
// master = control/RAM/UART side, slave = sequencer.
interface dump_sequencer_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          dump_req;
  logic [1:0]    dump_ch;
  logic [AW-1:0] start_addr;
  logic          capture_busy;
  logic          dump_abort;
  logic [AW-1:0] ram_addr;
  logic [2:0]    ram_en;
  logic [DW-1:0] ch1_rdata;
  logic [DW-1:0] ch2_rdata;
  logic [DW-1:0] ch3_rdata;
  logic [DW-1:0] tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          tx_done;
  logic          dump_busy;
  logic          dump_fin;
  logic          dump_err;

  modport master (
    output dump_req, dump_ch, start_addr, capture_busy, dump_abort,
    output ch1_rdata, ch2_rdata, ch3_rdata, tx_busy, tx_done,
    input  ram_addr, ram_en, tx_data, tx_start, dump_busy, dump_fin, dump_err
  );

  modport slave (
    input  dump_req, dump_ch, start_addr, capture_busy, dump_abort,
    input  ch1_rdata, ch2_rdata, ch3_rdata, tx_busy, tx_done,
    output ram_addr, ram_en, tx_data, tx_start, dump_busy, dump_fin, dump_err
  );
endinterface

// File: rtl/dump_sequencer.sv
// Streams one channel trace from the capture RAMs to the UART, oldest sample
// first, wrapping circularly from a latched start address.
module dump_sequencer #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  dump_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, LAT, SEND, WAIT_TX, FIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [AW:0]   cnt, cnt_nxt;
  logic [1:0]    ch, ch_nxt;
  logic [DW-1:0] rdata_sel;
  logic [2:0]    en_dec;
  logic          req_bad, last, abort;

  assign req_bad = bus.dump_req && ((bus.dump_ch == 2'd0) || bus.capture_busy);
  assign last    = (cnt == (AW+1)'(DEPTH-1));
  assign abort   = (state != IDLE) && bus.dump_abort;

  // Read enable is one-hot on the latched channel, only while in RD.
  for (genvar i = 0; i < 3; i++) begin : g_ch
    assign en_dec[i] = (state == RD) && (ch == 2'(i+1));
  end
  assign bus.ram_en   = en_dec;
  assign bus.ram_addr = (state == RD) ? ptr : '0;

  always_comb begin
    rdata_sel = '0;
    case (ch)
      2'd1:    rdata_sel = bus.ch1_rdata;
      2'd2:    rdata_sel = bus.ch2_rdata;
      2'd3:    rdata_sel = bus.ch3_rdata;
      default: rdata_sel = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    ch_nxt    = ch;
    case (state)
      IDLE: if (bus.dump_req && !req_bad) begin
        ch_nxt    = bus.dump_ch;
        ptr_nxt   = bus.start_addr;
        cnt_nxt   = '0;
        state_nxt = RD;
      end
      RD:   state_nxt = LAT;
      LAT:  state_nxt = SEND;
      SEND: if (!bus.tx_busy) state_nxt = WAIT_TX;
      WAIT_TX: if (bus.tx_done) begin
        if (last) state_nxt = FIN;
        else begin
          ptr_nxt   = ptr + 1'b1;
          cnt_nxt   = cnt + 1'b1;
          state_nxt = RD;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides any transition, including a same-cycle tx_done.
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      ch            <= '0;
      bus.tx_data   <= '0;
      bus.tx_start  <= 1'b0;
      bus.dump_busy <= 1'b0;
      bus.dump_fin  <= 1'b0;
      bus.dump_err  <= 1'b0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      cnt           <= cnt_nxt;
      ch            <= ch_nxt;
      if (state == LAT) bus.tx_data <= rdata_sel;
      // Registered pulses line up with the state they announce.
      bus.tx_start  <= (state == SEND) && (state_nxt == WAIT_TX);
      bus.dump_fin  <= (state_nxt == FIN);
      bus.dump_busy <= (state_nxt != IDLE);
      bus.dump_err  <= (state == IDLE) && req_bad;
    end
  end

endmodule

// File: tb/tb_dump_sequencer.sv
// Randomized scoreboard bench for dump_sequencer: expected RAM reads and bytes
// are queued at request time and popped by an independent monitor.
module tb_dump_sequencer;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int BUDGET = 30000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dump_sequencer_if #(.AW(AW), .DW(DW)) bus ();
  dump_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    en;
  } rd_exp_t;

  logic [DW-1:0] mem [3][DEPTH];
  rd_exp_t       rd_q[$];
  logic [DW-1:0] tx_q[$];

  int total = 0, bad = 0;
  int starts_seen = 0, fin_seen = 0, err_seen = 0, done_cnt = 0;
  int k_fix = 3;
  bit k_rand = 1'b0;
  int abort_at = -1;
  bit aborted = 1'b0;

  // Synchronous-read RAM model, one cycle latency.
  always @(posedge clk) begin
    if (bus.ram_en[0]) bus.ch1_rdata <= mem[0][bus.ram_addr];
    if (bus.ram_en[1]) bus.ch2_rdata <= mem[1][bus.ram_addr];
    if (bus.ram_en[2]) bus.ch3_rdata <= mem[2][bus.ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Transmitter model: tx_done k cycles after each tx_start; optional abort on the Nth done.
  initial begin
    int k;
    bus.tx_done = 1'b0;
    bus.dump_abort = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx_start) begin
        k = k_rand ? int'($urandom_range(1, 4)) : k_fix;
        repeat (k) @(posedge clk);
        #1;
        bus.tx_done = 1'b1;
        done_cnt++;
        if (done_cnt == abort_at) begin
          bus.dump_abort = 1'b1;
          aborted = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.tx_done = 1'b0;
        bus.dump_abort = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT reads RAM or starts a byte.
  initial begin
    rd_exp_t e;
    logic prev_txbusy, prev_fin;
    prev_txbusy = 1'b0;
    prev_fin = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.ram_en != 3'b000) begin
          if (rd_q.size() == 0) chk("unexpected_rd", 32'(bus.ram_en), 32'd0);
          else begin
            e = rd_q.pop_front();
            chk("ram_addr", 32'(bus.ram_addr), 32'(e.addr));
            chk("ram_en", 32'(bus.ram_en), 32'(e.en));
          end
        end
        if (bus.tx_start) begin
          starts_seen++;
          chk("start_while_busy", 32'(prev_txbusy), 32'd0);
          if (tx_q.size() == 0) chk("unexpected_tx", 32'd1, 32'd0);
          else chk("tx_data", 32'(bus.tx_data), 32'(tx_q.pop_front()));
        end
        if (bus.dump_fin) begin
          fin_seen++;
          chk("busy_at_fin", 32'(bus.dump_busy), 32'd1);
        end
        if (prev_fin) chk("busy_after_fin", 32'(bus.dump_busy), 32'd0);
        if (bus.dump_err) err_seen++;
      end
      prev_txbusy = bus.tx_busy;
      prev_fin = bus.dump_fin;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input int ch, input int start);
    int a;
    for (int i = 0; i < DEPTH; i++) begin
      a = (start + i) % DEPTH;
      rd_q.push_back('{addr: AW'(a), en: 3'(1 << (ch - 1))});
      tx_q.push_back(mem[ch-1][a]);
    end
  endtask

  task automatic issue(input int ch, input int start, input bit cap);
    bus.dump_req = 1'b1;
    bus.dump_ch = 2'(ch);
    bus.start_addr = AW'(start);
    bus.capture_busy = cap;
    cyc(1);
    bus.dump_req = 1'b0;
    bus.capture_busy = 1'b0;
  endtask

  task automatic wait_fin(input int n0, input string name);
    int t;
    t = 0;
    while (fin_seen == n0 && t < BUDGET) begin
      cyc(1);
      t++;
    end
    chk(name, 32'(fin_seen), 32'(n0 + 1));
    cyc(2);
  endtask

  task automatic wait_starts(input int target, input string name);
    int t;
    t = 0;
    while (starts_seen < target && t < BUDGET) begin
      cyc(1);
      t++;
    end
    if (starts_seen < target) chk(name, 32'(starts_seen), 32'(target));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ram_en"}, 32'(bus.ram_en), 32'd0);
    chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    chk({tag, "_busy"}, 32'(bus.dump_busy), 32'd0);
    chk({tag, "_fin"}, 32'(bus.dump_fin), 32'd0);
    chk({tag, "_err"}, 32'(bus.dump_err), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, f0, e0, ch, st;
    bus.dump_req = 1'b0;
    bus.dump_ch = '0;
    bus.start_addr = '0;
    bus.capture_busy = 1'b0;
    bus.tx_busy = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < DEPTH; j++) mem[i][j] = DW'($urandom);

    #12;
    chk_outputs_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(2);

    // Full dump on ch2 from 0x1F0 with a tx_busy stall and an ignored second request.
    k_fix = 3;
    s0 = starts_seen; f0 = fin_seen; e0 = err_seen;
    push_dump(2, 'h1F0);
    issue(2, 'h1F0, 1'b0);
    chk("busy_after_req", 32'(bus.dump_busy), 32'd1);
    wait_starts(s0 + 10, "t1_reach10");
    bus.tx_busy = 1'b1;
    cyc(6);
    issue(1, 5, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_no_start", 32'(bus.tx_start), 32'd0);
      chk("stall_data", 32'(bus.tx_data), 32'(mem[1][('h1F0 + 10) % DEPTH]));
    end
    @(posedge clk);
    #1 bus.tx_busy = 1'b0;
    wait_fin(f0, "t1_fin");
    chk("t1_starts", 32'(starts_seen - s0), 32'(DEPTH));
    chk("t1_rd_left", 32'(rd_q.size()), 32'd0);
    chk("t1_tx_left", 32'(tx_q.size()), 32'd0);
    chk("t1_no_err", 32'(err_seen - e0), 32'd0);

    // Rejected requests.
    issue(0, 3, 1'b0);
    cyc(2);
    chk("err_ch0", 32'(err_seen - e0), 32'd1);
    chk("err_ch0_busy", 32'(bus.dump_busy), 32'd0);
    issue(1, 3, 1'b1);
    cyc(2);
    chk("err_capbusy", 32'(err_seen - e0), 32'd2);
    chk("err_capbusy_busy", 32'(bus.dump_busy), 32'd0);

    // Abort together with the 100th tx_done.
    k_rand = 1'b1;
    s0 = starts_seen; f0 = fin_seen;
    ch = 1; st = int'($urandom_range(0, DEPTH - 1));
    abort_at = done_cnt + 100;
    push_dump(ch, st);
    issue(ch, st, 1'b0);
    for (int t = 0; t < BUDGET && !aborted; t++) cyc(1);
    chk("abort_seen", 32'(aborted), 32'd1);
    cyc(1);
    rd_q.delete();
    tx_q.delete();
    abort_at = -1;
    aborted = 1'b0;
    chk("abort_starts", 32'(starts_seen - s0), 32'd100);
    chk("abort_busy", 32'(bus.dump_busy), 32'd0);
    cyc(20);
    chk("abort_no_fin", 32'(fin_seen), 32'(f0));

    // Normal dump after abort, random channel 3 start.
    s0 = starts_seen; f0 = fin_seen;
    ch = 3; st = int'($urandom_range(0, DEPTH - 1));
    push_dump(ch, st);
    issue(ch, st, 1'b0);
    wait_fin(f0, "t4_fin");
    chk("t4_starts", 32'(starts_seen - s0), 32'(DEPTH));
    chk("t4_rd_left", 32'(rd_q.size()), 32'd0);

    // Asynchronous reset while waiting on byte 300.
    s0 = starts_seen; f0 = fin_seen;
    ch = int'($urandom_range(1, 3)); st = int'($urandom_range(0, DEPTH - 1));
    push_dump(ch, st);
    issue(ch, st, 1'b0);
    wait_starts(s0 + 301, "t5_reach301");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    rd_q.delete();
    tx_q.delete();
    cyc(10);
    rst_n = 1'b1;
    cyc(3);
    chk("reset_no_fin", 32'(fin_seen), 32'(f0));

    s0 = starts_seen;
    push_dump(3, 0);
    issue(3, 0, 1'b0);
    wait_fin(f0, "t5_fin");
    chk("t5_starts", 32'(starts_seen - s0), 32'(DEPTH));
    chk("t5_rd_left", 32'(rd_q.size()), 32'd0);
    chk("t5_tx_left", 32'(tx_q.size()), 32'd0);
    chk("final_err", 32'(err_seen - e0), 32'd2);

    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
